// File: rtl/life_scan_ctrl.sv
// life_scan_ctrl: runs a job of serial load, generation run and recirculating dump
// for a scan-chained life_cell array.
module life_scan_ctrl #(
   parameter int CHAIN_LEN = 64,
   parameter int GEN_W     = 16,
   parameter int CNT_W     = $clog2(CHAIN_LEN+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [GEN_W-1:0] gen_count,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   input  logic             chain_out,
   output logic             scan,
   output logic             scan_val,
   output logic             enb,
   output logic             out_valid,
   output logic             out_bit,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, DONE} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN-1);
   state_t           state, state_nx;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
   logic [GEN_W-1:0] gen_cnt, gen_cnt_nx;
   logic             last_bit;
   assign last_bit = bit_cnt == LAST;
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         gen_cnt <= '0;
      end else begin
         state   <= state_nx;
         bit_cnt <= bit_cnt_nx;
         gen_cnt <= gen_cnt_nx;
      end
   always_comb begin
      state_nx   = state;
      bit_cnt_nx = bit_cnt;
      gen_cnt_nx = gen_cnt;
      in_ready   = 1'b0;
      scan       = 1'b0;
      scan_val   = 1'b0;
      enb        = 1'b0;
      out_valid  = 1'b0;
      out_bit    = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_nx   = LOAD;
            gen_cnt_nx = gen_count;
            bit_cnt_nx = '0;
         end
         LOAD: begin
            in_ready = 1'b1;
            scan     = in_valid;
            scan_val = in_bit;
            if (in_valid) begin
               bit_cnt_nx = last_bit ? '0 : bit_cnt + 1'b1;
               if (last_bit) state_nx = (gen_cnt != '0) ? RUN : DUMP;
            end
         end
         RUN: begin
            enb        = 1'b1;
            gen_cnt_nx = gen_cnt - 1'b1;
            if (gen_cnt == GEN_W'(1)) state_nx = DUMP;
         end
         DUMP: begin
            out_valid = 1'b1;
            out_bit   = chain_out;
            // recirculate the bit just read so the array is left unchanged
            if (out_ready) begin
               scan       = 1'b1;
               scan_val   = chain_out;
               bit_cnt_nx = last_bit ? '0 : bit_cnt + 1'b1;
               if (last_bit) state_nx = DONE;
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_life_scan_ctrl.sv
// tb_life_scan_ctrl: directed jobs against a 4-stage behavioural chain whose
// generation step inverts every cell, with a scoreboard of expected readout bits.
module tb_life_scan_ctrl;
   localparam int L = 4;
   logic        clk = 0, reset = 0, start = 0, in_valid = 0, in_bit = 0, out_ready = 0;
   logic [15:0] gen_count = '0;
   logic        in_ready, chain_out, scan, scan_val, enb, out_valid, out_bit, busy, done;
   logic [L-1:0] arr = '0;
   int          enb_cnt = 0;
   int          checks = 0, errors = 0;
   logic        q[$];

   life_scan_ctrl #(.CHAIN_LEN(L), .GEN_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .gen_count(gen_count),
      .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
      .chain_out(chain_out), .scan(scan), .scan_val(scan_val), .enb(enb),
      .out_valid(out_valid), .out_bit(out_bit), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   assign chain_out = arr[L-1];
   always @(posedge clk) begin
      if (scan) arr <= {arr[L-2:0], scan_val};
      else if (enb) arr <= ~arr;
      if (enb) enb_cnt <= enb_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) if (reset && scan && enb) chk("scan_enb_excl", 1, 0);

   task automatic job(input logic [L-1:0] pat, input int gen, input bit gap,
                      input int stall_at, input bit poke, input bit abort);
      int e0, guard, got;
      logic held;
      logic [L-1:0] pre;
      @(negedge clk);
      start = 1; gen_count = 16'(gen);
      @(negedge clk);
      start = 0;
      e0 = enb_cnt;
      chk("busy_load", busy, 1);
      for (int i = 0; i < L; i++) begin
         if (poke) begin start = 1; gen_count = 16'd7; end
         if (gap) begin
            in_valid = 0; #1;
            chk("gap_scan", scan, 0);
            chk("gap_ready", in_ready, 1);
            @(negedge clk);
         end
         in_valid = 1; in_bit = pat[i]; #1;
         chk("load_scan", scan, 1);
         chk("load_val", scan_val, pat[i]);
         q.push_back(pat[i] ^ gen[0]);
         @(negedge clk);
      end
      in_valid = 0; start = 0;
      if (abort) begin
         repeat (5) @(negedge clk);
         chk("run_enb", enb, 1);
         #2 reset = 0; #1;
         chk("abort_enb", enb, 0);
         chk("abort_busy", busy, 0);
         chk("abort_scan", scan, 0);
         @(negedge clk);
         chk("abort_idle", busy, 0);
         reset = 1;
         q.delete();
         return;
      end
      guard = 0;
      while (!out_valid && guard < 300) begin
         @(negedge clk); guard++;
      end
      if (guard >= 300) chk("dump_timeout", 0, 1);
      chk("enb_cycles", enb_cnt - e0, gen);
      pre = arr;
      got = 0; guard = 0;
      while (got < L && guard < 100) begin
         if (got == stall_at) begin
            out_ready = 0; #1; held = out_bit;
            repeat (5) begin
               chk("stall_scan", scan, 0);
               chk("stall_bit", out_bit, held);
               @(negedge clk); #1;
            end
            stall_at = -1;
         end
         out_ready = 1; #1;
         if (out_valid) begin
            chk("dump_bit", out_bit, q.pop_front());
            chk("dump_scan", scan, 1);
            chk("dump_recirc", scan_val, out_bit);
            got++;
         end
         @(negedge clk); guard++;
      end
      out_ready = 0;
      if (guard >= 100) chk("dump_count_timeout", 0, 1);
      chk("done_pulse", done, 1);
      chk("done_out_valid", out_valid, 0);
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("idle_busy", busy, 0);
      chk("recirc_array", arr, pre);
      chk("q_empty", q.size(), 0);
   endtask

   initial begin
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_scan", scan, 0);
      chk("rst_enb", enb, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_bit", out_bit, 0);
      chk("rst_done", done, 0);
      @(negedge clk); reset = 1;
      job(4'b0001, 0, 0, -1, 0, 0);
      job(4'b1101, 1, 1, 2, 0, 0);
      job(4'b0110, 2, 0, 1, 1, 0);
      job(4'b1010, 100, 0, -1, 0, 1);
      job(4'b1011, 3, 0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/life_scan_ctrl.md
LIFE_SCAN_CTRL -- requirements
Module: life_scan_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 64, number of life_cell stages in the array scan chain.
REQ-002 Parameter GEN_W, default 16, width of the generation-count input.
REQ-003 Parameter CNT_W, default $clog2(CHAIN_LEN+1), width of the internal bit counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a load/run/dump job.
REQ-007 gen_count  input  GEN_W  generations to run; sampled on accepted start.
REQ-008 in_valid  input  1  serial pattern bit available.
REQ-009 in_bit  input  1  serial pattern bit; 1 = alive.
REQ-010 in_ready  output  1  controller accepts in_bit this cycle.
REQ-011 chain_out  input  1  alive output of the last cell in the scan chain.
REQ-012 scan  output  1  array-wide scan-shift enable.
REQ-013 scan_val  output  1  bit shifted into the first cell of the chain.
REQ-014 enb  output  1  array-wide generation-step enable.
REQ-015 out_valid  output  1  readout bit available.
REQ-016 out_bit  output  1  readout bit; equals chain_out.
REQ-017 out_ready  input  1  downstream accepts out_bit this cycle.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 done  output  1  one-cycle pulse at job completion.

Function
REQ-020 FSM states IDLE, LOAD, RUN, DUMP, DONE; one state per cycle, registered.
REQ-021 IDLE: start=1 latches gen_count, clears bit counter, goes to LOAD; start ignored in every other state.
REQ-022 LOAD: in_ready=1; scan=in_valid, scan_val=in_bit (combinational); each accepted bit increments bit counter.
REQ-023 LOAD exits when the CHAIN_LEN-th bit is accepted: to RUN if latched count>0, else directly to DUMP; bit counter cleared.
REQ-024 First accepted bit ends in the last cell (first-in, first-out through the chain).
REQ-025 RUN: enb=1 for exactly latched-count consecutive cycles, scan=0; generation counter decrements each cycle, goes to DUMP on the cycle it reaches 1.
REQ-026 DUMP: out_valid=1, out_bit=chain_out; on out_valid&out_ready, scan=1 with scan_val=chain_out (recirculate) and bit counter increments.
REQ-027 DUMP with out_ready=0: scan=0, out_bit held stable (array not shifted).
REQ-028 DUMP exits after the CHAIN_LEN-th accepted bit to DONE; array contents equal the pre-dump state after recirculation.
REQ-029 DONE: done=1 for one cycle, then IDLE.
REQ-030 scan and enb never both 1 in the same cycle; outside LOAD/DUMP scan=0, outside RUN enb=0.
REQ-031 in_ready=0 and out_valid=0 outside LOAD and DUMP respectively.
REQ-032 Counters saturate-free: bit counter range 0..CHAIN_LEN, generation counter range 0..2^GEN_W-1.

Reset
REQ-033 reset=0 at any time, including mid-LOAD/RUN/DUMP, forces IDLE asynchronously.
REQ-034 During and after reset: scan=0, scan_val=0, enb=0, in_ready=0, out_valid=0, out_bit follows chain_out only in DUMP (else 0), busy=0, done=0, counters 0.

Verification (CHAIN_LEN=4 array of life_cell unless noted)
REQ-035 Load 1,0,0,0 with gen_count=0, out_ready=1 -> no enb cycles; readout 1,0,0,0; done pulse; reload-free second dump yields same bits.
REQ-036 Blinker in 3x3 array (CHAIN_LEN=9) loaded, gen_count=1 -> exactly one enb cycle; readout shows rotated blinker; gen_count=2 -> original.
REQ-037 in_valid toggled every other cycle during LOAD -> scan asserted only on valid cycles; all 4 bits land correctly.
REQ-038 out_ready held 0 for 5 cycles mid-DUMP -> out_bit stable, scan=0, no bit lost or duplicated.
REQ-039 reset=0 during RUN with count 100 -> immediate IDLE, enb=0 same cycle, busy=0; subsequent start completes normally.
REQ-040 start pulsed while busy -> ignored; gen_count change mid-job has no effect.
